// File: rtl/grf_wb_arbiter.sv
// Shares the single GRF write port between W-stage writeback and queued MDU results; same-cycle grant.
// Aged FIFO head preempts the primary writer; a scoreboard of pending MDU destinations drives decode stall.
module grf_wb_arbiter #(
    parameter int DEPTH     = 2,
    parameter int AGE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        p_we,
    input  logic [4:0]  p_a3,
    input  logic [31:0] p_wd,
    input  logic [31:0] p_pc,
    output logic        p_stall,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic        issue_valid,
    input  logic [4:0]  issue_a3,
    input  logic [4:0]  rs_a,
    input  logic [4:0]  rt_a,
    output logic        stall,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc,
    output logic [5:0]  pend_cnt
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int GW = $clog2(AGE_LIMIT + 1);
    localparam logic [AW:0]   DEPTH_C = (AW + 1)'(DEPTH);
    localparam logic [GW-1:0] AGE_C   = GW'(AGE_LIMIT);

    logic [4:0]    fifo_a3 [DEPTH];
    logic [31:0]   fifo_wd [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [GW-1:0] age;
    logic [31:0]   sb;

    logic          head_vld;
    logic          full;
    logic          aged;
    logic          push;
    logic          pop;
    logic          sel_p;
    logic [4:0]    head_a3;
    logic [31:0]   clr_mask;
    logic [31:0]   set_mask;
    logic [31:0]   busy;

    assign head_vld = (count != '0);
    assign full     = (count == DEPTH_C);
    assign s_ready  = !full;
    assign push     = s_valid && !full;
    assign head_a3  = fifo_a3[rd_ptr];
    assign aged     = head_vld && (age >= AGE_C);
    assign pop      = head_vld && (aged || !p_we);
    assign sel_p    = p_we && !aged;
    assign p_stall  = p_we && aged;

    always_comb begin
        grf_we = 1'b0;
        grf_a3 = '0;
        grf_wd = '0;
        grf_pc = '0;
        if (pop) begin
            grf_a3 = head_a3;
            grf_wd = fifo_wd[rd_ptr];
            grf_pc = fifo_pc[rd_ptr];
            grf_we = (head_a3 != 5'd0);
        end else if (sel_p) begin
            grf_a3 = p_a3;
            grf_wd = p_wd;
            grf_pc = p_pc;
            grf_we = (p_a3 != 5'd0);
        end
    end

    always_comb begin
        clr_mask = '0;
        set_mask = '0;
        if (pop && head_a3 != 5'd0) clr_mask[head_a3] = 1'b1;
        if (issue_valid && issue_a3 != 5'd0) set_mask[issue_a3] = 1'b1;
    end

    // The register being written back now is covered by the GRF write-through bypass.
    assign busy  = sb & ~clr_mask;
    assign stall = (rs_a != 5'd0 && busy[rs_a]) ||
                   (rt_a != 5'd0 && busy[rt_a]) ||
                   (issue_valid && issue_a3 != 5'd0 && busy[issue_a3]);

    always_comb begin
        pend_cnt = '0;
        for (int i = 0; i < 32; i++) pend_cnt = pend_cnt + {5'd0, sb[i]};
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a3[wr_ptr] <= s_a3;
            fifo_wd[wr_ptr] <= s_wd;
            fifo_pc[wr_ptr] <= s_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            age    <= '0;
            sb     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + (AW + 1)'(1);
            else if (pop && !push) count <= count - (AW + 1)'(1);
            if (!head_vld || pop)  age <= '0;
            else if (age < AGE_C)  age <= age + GW'(1);
            // Clear first so a same-cycle issue to the popping register keeps it pending.
            sb <= (sb & ~clr_mask) | set_mask;
        end
    end
endmodule

// File: tb/tb_grf_wb_arbiter.sv
module tb_grf_wb_arbiter;
    localparam int DEPTH = 2;
    localparam int AL    = 4;

    logic        clk, reset;
    logic        p_we, p_stall, s_valid, s_ready, issue_valid, stall, grf_we;
    logic [4:0]  p_a3, s_a3, issue_a3, rs_a, rt_a, grf_a3;
    logic [31:0] p_wd, p_pc, s_wd, s_pc, grf_wd, grf_pc;
    logic [5:0]  pend_cnt;

    grf_wb_arbiter #(.DEPTH(DEPTH), .AGE_LIMIT(AL)) dut (
        .clk(clk), .reset(reset),
        .p_we(p_we), .p_a3(p_a3), .p_wd(p_wd), .p_pc(p_pc), .p_stall(p_stall),
        .s_valid(s_valid), .s_ready(s_ready), .s_a3(s_a3), .s_wd(s_wd), .s_pc(s_pc),
        .issue_valid(issue_valid), .issue_a3(issue_a3), .rs_a(rs_a), .rt_a(rt_a),
        .stall(stall), .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd),
        .grf_pc(grf_pc), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: queue of pending MDU results, age in cycles, pending-register set.
    typedef struct {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } ent_t;
    ent_t     q[$];
    int       m_age;
    bit [31:0] m_sb;
    bit       m_sec;
    logic        exp_we, exp_p_stall, exp_s_ready, exp_stall;
    logic [4:0]  exp_a3;
    logic [31:0] exp_wd, exp_pc;
    logic [5:0]  exp_pend;

    task automatic model_eval();
        ent_t w;
        bit aged, pri;
        bit [31:0] busy;
        aged  = (q.size() > 0) && (m_age >= AL);
        m_sec = (q.size() > 0) && (aged || !p_we);
        pri   = p_we && !aged;
        w.a3 = 0; w.wd = 0; w.pc = 0;
        if (m_sec) w = q[0];
        else if (pri) begin w.a3 = p_a3; w.wd = p_wd; w.pc = p_pc; end
        exp_a3 = w.a3; exp_wd = w.wd; exp_pc = w.pc;
        exp_we = (m_sec || pri) && (w.a3 != 0);
        exp_p_stall = p_we && aged;
        exp_s_ready = (q.size() < DEPTH);
        busy = m_sb;
        if (m_sec && w.a3 != 0) busy[w.a3] = 1'b0;
        exp_stall = (rs_a != 0 && busy[rs_a]) || (rt_a != 0 && busy[rt_a]) ||
                    (issue_valid && issue_a3 != 0 && busy[issue_a3]);
        exp_pend = 6'($countones(m_sb));
    endtask

    task automatic model_commit();
        ent_t e;
        bit acc, had;
        if (reset) begin
            q.delete(); m_age = 0; m_sb = 0;
        end else begin
            acc = s_valid && (q.size() < DEPTH);
            had = q.size() > 0;
            if (m_sec) begin
                e = q.pop_front();
                if (e.a3 != 0) m_sb[e.a3] = 1'b0;
            end
            if (acc) begin
                e.a3 = s_a3; e.wd = s_wd; e.pc = s_pc;
                q.push_back(e);
            end
            if (issue_valid && issue_a3 != 0) m_sb[issue_a3] = 1'b1;
            if (!had || m_sec) m_age = 0;
            else if (m_age < AL) m_age++;
        end
    endtask

    task automatic settle();
        #1;
        model_eval();
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        model_commit();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        p_we = 0; p_a3 = 0; p_wd = 0; p_pc = 0;
        s_valid = 0; s_a3 = 0; s_wd = 0; s_pc = 0;
        issue_valid = 0; issue_a3 = 0; rs_a = 0; rt_a = 0;
    endtask

    task automatic test_reset();
        reset = 1; idle_inputs();
        tick(); tick();
        reset = 0;
        p_we = 1; p_a3 = 1; s_valid = 1; s_a3 = 8; s_wd = 32'h11;
        issue_valid = 1; issue_a3 = 8;
        tick();
        issue_valid = 0; s_wd = 32'h22;
        tick();
        s_valid = 0;
        settle();
        checks++;
        if ({s_ready, pend_cnt} !== {1'b0, 6'd1}) begin
            errors++; $display("FAIL pre_reset_full got %b want %b", {s_ready, pend_cnt}, {1'b0, 6'd1});
        end
        reset = 1; idle_inputs();
        tick();
        reset = 0; rs_a = 8;
        settle();
        checks++;
        if ({s_ready, pend_cnt, grf_we, stall, p_stall} !== {1'b1, 6'd0, 1'b0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset_state got %b want 100000000", {s_ready, pend_cnt, grf_we, stall, p_stall});
        end
        checks++;
        if ({grf_a3, grf_wd, grf_pc} !== 69'd0) begin
            errors++; $display("FAIL reset_bus got %h want 0", {grf_a3, grf_wd, grf_pc});
        end
        rs_a = 0;
    endtask

    task automatic test_primary();
        p_we = 1; p_a3 = 5; p_wd = 32'h1234; p_pc = 32'h400;
        settle();
        checks++;
        if ({grf_we, grf_a3, grf_wd, grf_pc, p_stall} !== {1'b1, 5'd5, 32'h1234, 32'h400, 1'b0}) begin
            errors++; $display("FAIL primary_write got %h want %h", {grf_we, grf_a3, grf_wd, grf_pc, p_stall},
                               {1'b1, 5'd5, 32'h1234, 32'h400, 1'b0});
        end
        tick();
        p_we = 0;
    endtask

    task automatic test_scoreboard();
        issue_valid = 1; issue_a3 = 9;
        tick();
        issue_valid = 0; rs_a = 9;
        settle();
        checks++;
        if ({pend_cnt, stall} !== {6'd1, 1'b1}) begin
            errors++; $display("FAIL sb_set got %b want 0000011", {pend_cnt, stall});
        end
        s_valid = 1; s_a3 = 9; s_wd = 32'hBEEF; s_pc = 32'h500;
        tick();
        s_valid = 0;
        settle();
        checks++;
        if ({grf_we, grf_a3, grf_wd, stall} !== {1'b1, 5'd9, 32'hBEEF, 1'b0}) begin
            errors++; $display("FAIL mdu_write got %h want %h", {grf_we, grf_a3, grf_wd, stall},
                               {1'b1, 5'd9, 32'hBEEF, 1'b0});
        end
        tick();
        settle();
        checks++;
        if ({pend_cnt, stall, grf_we} !== {6'd0, 1'b0, 1'b0}) begin
            errors++; $display("FAIL sb_clear got %b want 00000000", {pend_cnt, stall, grf_we});
        end
        rs_a = 0;
    endtask

    task automatic test_aging();
        p_we = 1; p_a3 = 6; p_wd = 32'h66;
        s_valid = 1; s_a3 = 7; s_wd = 32'hA7;
        tick();
        s_valid = 0;
        for (int k = 0; k < AL; k++) begin
            settle();
            checks++;
            if ({grf_a3, p_stall} !== {5'd6, 1'b0}) begin
                errors++; $display("FAIL age_primary_%0d got a3=%0d p_stall=%0d want a3=6 p_stall=0", k, grf_a3, p_stall);
            end
            tick();
        end
        settle();
        checks++;
        if ({grf_we, grf_a3, grf_wd, p_stall} !== {1'b1, 5'd7, 32'hA7, 1'b1}) begin
            errors++; $display("FAIL age_preempt got a3=%0d wd=%h p_stall=%0d want a3=7 wd=a7 p_stall=1",
                               grf_a3, grf_wd, p_stall);
        end
        tick();
        settle();
        checks++;
        if ({grf_a3, p_stall, s_ready} !== {5'd6, 1'b0, 1'b1}) begin
            errors++; $display("FAIL age_after got a3=%0d p_stall=%0d want a3=6 p_stall=0", grf_a3, p_stall);
        end
        tick();
        p_we = 0;
    endtask

    task automatic test_back_to_back();
        int n = 0;
        p_we = 1; p_a3 = 2; p_wd = 32'h2;
        s_valid = 1; s_a3 = 10; s_wd = 32'hC0;
        for (int c = 0; c < 12; c++) begin
            bit acc;
            settle();
            if (c == 2) begin
                checks++;
                if (s_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_full got s_ready=%0d want 0", s_ready);
                end
            end
            checks++;
            if ({s_ready, grf_a3, grf_wd, p_stall} !== {exp_s_ready, exp_a3, exp_wd, exp_p_stall}) begin
                errors++; $display("FAIL bp_cycle_%0d got %h want %h", c, {s_ready, grf_a3, grf_wd, p_stall},
                                   {exp_s_ready, exp_a3, exp_wd, exp_p_stall});
            end
            acc = s_valid && exp_s_ready;
            tick();
            if (acc) begin
                n++; s_a3 = 5'(10 + n); s_wd = 32'hC0 + n;
                if (n == 3) s_valid = 0;
            end
        end
        checks++;
        if (n != 3) begin
            errors++; $display("FAIL bp_accepted got %0d want 3", n);
        end
        p_we = 0;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if ({grf_we, grf_a3, grf_wd} !== {exp_we, exp_a3, exp_wd}) begin
                errors++; $display("FAIL bp_drain_%0d got %h want %h", c, {grf_we, grf_a3, grf_wd}, {exp_we, exp_a3, exp_wd});
            end
            tick();
        end
    endtask

    task automatic test_zero_and_set_wins();
        s_valid = 1; s_a3 = 0; s_wd = 32'h77;
        tick();
        s_valid = 0;
        settle();
        checks++;
        if ({grf_we, grf_wd} !== {1'b0, 32'h77}) begin
            errors++; $display("FAIL a3_zero got we=%0d wd=%h want we=0 wd=77", grf_we, grf_wd);
        end
        tick();
        issue_valid = 1; issue_a3 = 3;
        tick();
        issue_valid = 0; s_valid = 1; s_a3 = 3; s_wd = 32'h33;
        tick();
        s_valid = 0; issue_valid = 1; issue_a3 = 3;
        settle();
        checks++;
        if ({grf_we, grf_a3, stall} !== {1'b1, 5'd3, 1'b0}) begin
            errors++; $display("FAIL set_wins_pop got we=%0d a3=%0d stall=%0d want 1 3 0", grf_we, grf_a3, stall);
        end
        tick();
        issue_valid = 0; rs_a = 3;
        settle();
        checks++;
        if ({pend_cnt, stall} !== {6'd1, 1'b1}) begin
            errors++; $display("FAIL set_wins got pend=%0d stall=%0d want 1 1", pend_cnt, stall);
        end
        rs_a = 0; s_valid = 1;
        tick();
        s_valid = 0;
        tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            reset = ($urandom_range(0, 63) == 0);
            p_we = $urandom_range(0, 1); p_a3 = 5'($urandom_range(0, 7));
            p_wd = $urandom; p_pc = $urandom;
            s_valid = ($urandom_range(0, 2) == 0); s_a3 = 5'($urandom_range(0, 7));
            s_wd = $urandom; s_pc = $urandom;
            issue_valid = ($urandom_range(0, 2) == 0); issue_a3 = 5'($urandom_range(0, 7));
            rs_a = 5'($urandom_range(0, 7)); rt_a = 5'($urandom_range(0, 7));
            settle();
            checks++;
            if ({grf_we, grf_a3, grf_wd, grf_pc} !== {exp_we, exp_a3, exp_wd, exp_pc}) begin
                errors++; $display("FAIL rnd_write_%0d got %h want %h", c, {grf_we, grf_a3, grf_wd, grf_pc},
                                   {exp_we, exp_a3, exp_wd, exp_pc});
            end
            checks++;
            if ({p_stall, s_ready, stall, pend_cnt} !== {exp_p_stall, exp_s_ready, exp_stall, exp_pend}) begin
                errors++; $display("FAIL rnd_ctrl_%0d got %b want %b", c, {p_stall, s_ready, stall, pend_cnt},
                                   {exp_p_stall, exp_s_ready, exp_stall, exp_pend});
            end
            tick();
        end
        reset = 0; idle_inputs();
    endtask

    initial begin
        m_age = 0; m_sb = 0;
        reset = 1; idle_inputs();
        @(negedge clk);
        test_reset();
        test_primary();
        test_scoreboard();
        test_aging();
        test_back_to_back();
        test_zero_and_set_wins();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Owns the single write port of the GRF and shares it between two writers.
- Primary writer is the pipeline W-stage writeback. Secondary writer is the long-latency multiply/divide unit (MDU) result return, which uses a valid/ready handshake and a small holding FIFO.
- Keeps a 32-entry scoreboard of registers that have an outstanding MDU result. From it, generates the decode-stage stall.
- Sits between the W stage / MDU and the GRF write inputs (WE, A3, WD, PC).

Parameters:
- DEPTH, 2, entries in the secondary holding FIFO (power of 2, >=2).
- AGE_LIMIT, 4, cycles the FIFO head may wait before it preempts the primary writer (>=1).

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high; clock clk.
- p_we  in  1  primary write request this cycle.
- p_a3  in  5  primary destination register.
- p_wd  in  32  primary write data.
- p_pc  in  32  primary instruction PC.
- p_stall  out  1  primary write not taken this cycle; W stage must hold its values.
- s_valid  in  1  MDU result valid.
- s_ready  out  1  FIFO can accept an entry.
- s_a3  in  5  MDU destination register.
- s_wd  in  32  MDU result data.
- s_pc  in  32  MDU instruction PC.
- issue_valid  in  1  an MDU op writing a GRF register issues this cycle.
- issue_a3  in  5  destination of the issuing op.
- rs_a  in  5  decode read address 1.
- rt_a  in  5  decode read address 2.
- stall  out  1  decode must stall (RAW/WAW on a pending register).
- grf_we  out  1  GRF write enable.
- grf_a3  out  5  GRF write address.
- grf_wd  out  32  GRF write data.
- grf_pc  out  32  PC forwarded to the GRF for trace.
- pend_cnt  out  6  number of scoreboard bits set.

Behaviour:
- Reset (synchronous): FIFO emptied, age=0, scoreboard=0. Outputs settle to s_ready=1, stall=0, p_stall=0, grf_we=0, grf_a3=0, grf_wd=0, grf_pc=0, pend_cnt=0. Reset mid-operation discards queued MDU results and pending bits.
- FIFO:
  - Push when s_valid && s_ready. s_ready = !full, computed from registered state only.
  - A full FIFO refuses a push even in a cycle where it pops.
  - Order is FIFO; the head is visible combinationally.
- Grant (combinational, same cycle as request). Let h = FIFO non-empty.
  - If h && (age >= AGE_LIMIT): secondary wins. FIFO pops; p_stall = p_we.
  - Else if p_we: primary wins; p_stall = 0.
  - Else if h: secondary wins; FIFO pops.
  - Else: no write.
- Write outputs:
  - grf_a3/grf_wd/grf_pc come from the winner; all-zero when there is no winner.
  - grf_we = winner exists && winner a3 != 0.
  - A secondary entry with a3=0 still pops but does not write.
- Age counter:
  - Resets to 0 on a pop or when the FIFO is empty.
  - Otherwise increments each cycle, saturating at AGE_LIMIT.
- Scoreboard:
  - Bit r is set on issue_valid with issue_a3=r (r != 0).
  - Bit r is cleared when a secondary entry with a3=r pops.
  - Set and clear of the same r in the same cycle: set wins.
  - pend_cnt = popcount, updated with the registered state.
- Stall (combinational from registered scoreboard):
  - stall = (rs_a != 0 && sb[rs_a]) || (rt_a != 0 && sb[rt_a]) || (issue_valid && issue_a3 != 0 && sb[issue_a3]).
  - Writer is responsible for not issuing while stall=1.
- Primary writes do not touch the scoreboard.
- The GRF's own write-through bypass covers same-cycle reads of the grf_a3 register, so stall ignores the register being written this cycle.

Test Plan:
- Reset with FIFO holding 2 entries and sb[8]=1 -> next cycle s_ready=1, pend_cnt=0, grf_we=0, stall=0.
- p_we=1, p_a3=5, p_wd=0x1234, FIFO empty -> same cycle grf_we=1, grf_a3=5, grf_wd=0x1234, p_stall=0.
- issue_valid, issue_a3=9 -> sb[9]=1, pend_cnt=1. Then rs_a=9 gives stall=1. Push s_a3=9, s_wd=0xBEEF with p_we=0 -> written and popped the next cycle, stall drops to 0.
- FIFO head queued while p_we=1 held continuously, AGE_LIMIT=4 -> primary wins 4 cycles. In the 5th cycle the head is written, p_stall=1 and age resets.
- Push 2 entries with p_we=1 held (DEPTH=2) -> s_ready=0, third s_valid not accepted until a pop frees an entry.
- Secondary entry with s_a3=0 -> popped, grf_we=0. Issue to reg 3 in the same cycle that a pop clears reg 3 -> sb[3] remains 1.
